// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle restoring divider: state encoding,
// default operand width and iteration-counter sizing.
package div_ctrl_pkg;

  localparam int unsigned DIV_DATA_W = 32;

  // Counter only has to reach DATA_W-1, so log2(DATA_W) bits suffice
  function automatic int unsigned div_cnt_w(input int unsigned data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

  localparam int unsigned DIV_CNT_W = div_cnt_w(DIV_DATA_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              bit_i,
  input  logic [DATA_W-1:0] dvs_i,
  output logic [DATA_W-1:0] rem_c,
  output logic              q_bit_c
);

  logic [DATA_W:0] partial;
  logic [DATA_W:0] trial;

  // rem_i < dvs_i always holds, so a restored or reduced remainder fits DATA_W bits
  always_comb begin
    partial = {rem_i, bit_i};
    trial   = partial - {1'b0, dvs_i};
    q_bit_c = (partial >= {1'b0, dvs_i});
    rem_c   = q_bit_c ? trial[DATA_W-1:0] : partial[DATA_W-1:0];
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divider controller: one quotient bit per cycle,
// result {remainder, quotient} held while the requester keeps start high.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                annul,
  input  logic                signed_div,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  output logic [2*DATA_W-1:0] result,
  output logic                ready,
  output logic                stall_req
);

  localparam int unsigned CNT_W = div_cnt_w(DATA_W);
  localparam int unsigned RES_W = 2 * DATA_W;

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              ready_q, ready_d;

  logic              op1_neg, op2_neg;
  logic [DATA_W-1:0] op1_mag, op2_mag;
  logic [DATA_W-1:0] step_rem;
  logic              step_qbit;
  logic [DATA_W-1:0] quo_step;
  logic [DATA_W-1:0] quo_fix, rem_fix;

  // The dividend magnitude sits in quo_q and shifts out MSB-first as quotient bits shift in
  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i   (rem_q),
    .bit_i   (quo_q[DATA_W-1]),
    .dvs_i   (dvs_q),
    .rem_c   (step_rem),
    .q_bit_c (step_qbit)
  );

  always_comb begin
    op1_neg  = signed_div & opdata1[DATA_W-1];
    op2_neg  = signed_div & opdata2[DATA_W-1];
    op1_mag  = op1_neg ? (~opdata1 + DATA_W'(1)) : opdata1;
    op2_mag  = op2_neg ? (~opdata2 + DATA_W'(1)) : opdata2;
    quo_step = {quo_q[DATA_W-2:0], step_qbit};
    quo_fix  = neg_quo_q ? (~quo_step + DATA_W'(1)) : quo_step;
    rem_fix  = neg_rem_q ? (~step_rem + DATA_W'(1)) : step_rem;
  end

  // Next-state and datapath update; ready/result default low outside END
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = 1'b0;
    result_d  = '0;

    case (state_q)
      IDLE: begin
        if (start && !annul) begin
          neg_quo_d = op1_neg ^ op2_neg;
          neg_rem_d = op1_neg;
          rem_d     = '0;
          quo_d     = op1_mag;
          dvs_d     = op2_mag;
          cnt_d     = '0;
          state_d   = (opdata2 == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          state_d = END;
          ready_d = 1'b1;
        end
      end
      ON: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = END;
            ready_d  = 1'b1;
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      END: begin
        if (annul || !start) begin
          state_d = IDLE;
        end else begin
          ready_d  = 1'b1;
          result_d = result_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result = result_q;
  assign ready  = ready_q;

  // Gated by reset so a held start cannot stall the pipe during reset
  assign stall_req = reset & start & ~annul & (state_q != END);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: hand-computed quotients/remainders, latency,
// stall behaviour, annul and asynchronous reset.
module tb_div_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        annul;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  int n_cmp;
  int n_bad;

  div_ctrl #(.DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .annul      (annul),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Launch one divide, measure latency, then check hold and release behaviour
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp_res, input int exp_lat,
                         input bit annul_end, input bit wiggle);
    int lat;
    int stall_bad;
    lat       = -1;
    stall_bad = 0;
    @(posedge clk); #1;
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    annul      = 1'b0;
    start      = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1 && wiggle) begin
        opdata1    = ~a;
        opdata2    = 32'd3;
        signed_div = ~sgn;
      end
      if (ready) begin
        lat = c;
        break;
      end
      if (!stall_req) stall_bad++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
    check({tag, "_stall_end"}, 64'(stall_req), 64'd0);
    repeat (2) @(negedge clk);
    check({tag, "_hold_ready"}, 64'(ready), 64'd1);
    check({tag, "_hold_result"}, result, exp_res);
    if (annul_end) annul = 1'b1;
    else           start = 1'b0;
    @(negedge clk);
    check({tag, "_clr_ready"}, 64'(ready), 64'd0);
    check({tag, "_clr_result"}, result, 64'd0);
    start = 1'b0;
    annul = 1'b0;
  endtask

  initial begin
    int seen;
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b0;
    start      = 1'b1;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    #2;
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_result", result, 64'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_div("u100_7",   32'd100,        32'd7,          1'b0, {32'd2, 32'd14},                 33, 1'b0, 1'b0);
    run_div("s-7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD},  33, 1'b0, 1'b0);
    run_div("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0, 32'h8000_0000},          33, 1'b0, 1'b0);
    run_div("by_zero",  32'd5,          32'd0,          1'b0, 64'd0,                           2,  1'b0, 1'b0);
    run_div("s7_-2",    32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1, 32'hFFFF_FFFD},          33, 1'b1, 1'b0);
    run_div("u_max_10", 32'hFFFF_FFFF,  32'd10,         1'b0, {32'd5, 32'h1999_9999},          33, 1'b0, 1'b1);
    run_div("u_fff9_2", 32'hFFFF_FFF9,  32'd2,          1'b0, {32'd1, 32'h7FFF_FFFC},          33, 1'b0, 1'b0);

    // annul in ON cycle 10
    @(posedge clk); #1;
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    check("annul_ready", 64'(ready), 64'd0);
    annul = 1'b0;
    start = 1'b0;
    seen  = 0;
    repeat (30) begin
      @(negedge clk);
      if (ready) seen = 1;
    end
    check("annul_no_ready", 64'(seen), 64'd0);
    run_div("after_annul", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 1'b0, 1'b0);

    // asynchronous reset in ON cycle 15
    @(posedge clk); #1;
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(negedge clk);
    repeat (15) @(negedge clk);
    check("pre_rst_stall", 64'(stall_req), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_stall", 64'(stall_req), 64'd0);
    check("mid_rst_ready", 64'(ready), 64'd0);
    check("mid_rst_result", result, 64'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_div("after_rst", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the operand width; the result width is 2*DATA_W.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  divide request from EX; held high until the result is taken.
REQ-005 SHALL have port annul  input  1  cancel the in-flight divide (branch flush).
REQ-006 SHALL have port signed_div  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at acceptance.
REQ-007 SHALL have port opdata1  input  DATA_W  dividend; sampled at acceptance.
REQ-008 SHALL have port opdata2  input  DATA_W  divisor; sampled at acceptance.
REQ-009 SHALL have port result  output  2*DATA_W  {remainder (HI), quotient (LO)}.
REQ-010 SHALL have port ready  output  1  result valid.
REQ-011 SHALL have port stall_req  output  1  pipeline stall request to the stall controller.

Function
REQ-012 SHALL implement FSM states IDLE, BYZERO, ON, END.
REQ-013 IDLE: start=1, annul=0, opdata2!=0 -> ON; operands are latched and the iteration counter is cleared.
REQ-014 IDLE: start=1, annul=0, opdata2==0 -> BYZERO; BYZERO -> END on the next cycle with result=0.
REQ-015 IDLE: start=0 or annul=1 -> stay in IDLE.
REQ-016 ON SHALL do restoring division, one quotient bit per cycle, MSB first, with a (DATA_W+1)-bit trial subtract.
REQ-017 ON SHALL last exactly DATA_W cycles, then go to END.
REQ-018 Latency: start seen in IDLE at cycle 0 -> ready=1 in cycle DATA_W+1 (33 for DATA_W=32). Divide-by-zero -> ready in cycle 2.
REQ-019 Signed mode: operands SHALL be converted to magnitudes (two's complement) before iterating.
REQ-020 Signed mode: the quotient SHALL be negated when the operand signs differ.
REQ-021 Signed mode: the remainder SHALL take the sign of the dividend.
REQ-022 Signed mode: -2^(DATA_W-1) / -1 SHALL give quotient 0x80000000 (wrapped) and remainder 0.
REQ-023 END: ready=1 and result held stable while start=1.
REQ-024 END: start=0 -> IDLE, ready=0, result cleared to 0.
REQ-025 annul=1 in ON or BYZERO -> IDLE on the next edge, no ready pulse; annul has priority over completion.
REQ-026 annul=1 in END -> IDLE, ready=0.
REQ-027 stall_req SHALL be combinational: start & ~annul & (state!=END).
REQ-028 stall_req SHALL be high in the IDLE acceptance cycle and every ON/BYZERO cycle, and low in END.
REQ-029 Operand changes after acceptance SHALL NOT affect the in-flight result.
REQ-030 ready=0 and result=0 SHALL hold in every state other than END.

Reset
REQ-031 reset low SHALL asynchronously force state=IDLE, counter=0, latched operands=0, result=0, ready=0.
REQ-032 stall_req SHALL be 0 while reset is low, regardless of start.
REQ-033 Reset asserted mid-operation SHALL abort the divide; after release, a new start SHALL begin from IDLE normally.

Structure
REQ-034 A shared package SHALL hold the state encoding (2-bit enum: IDLE=0, BYZERO=1, ON=2, END=3), DATA_W default, and the counter width.
REQ-035 The FSM, counter and operand/partial-remainder registers SHALL live in div_ctrl.
REQ-036 The combinational shift-subtract step SHALL be one sub-module, div_step (partial remainder and divisor in; next remainder and quotient bit out).

Verification
REQ-037 Unsigned 100/7 (signed_div=0): result={32'd2, 32'd14}, ready first high in cycle 33, stall_req high cycles 0-32 and low in cycle 33.
REQ-038 Signed -7/2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-039 Signed 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-040 Divide by zero 5/0: ready in cycle 2 with result 0; start dropped -> IDLE next cycle.
REQ-041 annul pulsed in ON cycle 10: state IDLE at cycle 11, no ready pulse; a following 9/3 gives {0, 3}.
REQ-042 reset driven low in ON cycle 15: all outputs 0 immediately, without waiting for a clock edge; after release, 9/3 completes correctly.
